// File: rtl/cfu_pkg.sv
// Shared definitions for the control-flow sequencer: widths, opcodes, FSM states.
package cfu_pkg;

  localparam int unsigned PC_W        = 5;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned STACK_DEPTH = 16;
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH);

  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BEQ  = 5'b11001;
  localparam logic [4:0] OP_BNE  = 5'b11010;
  localparam logic [4:0] OP_BGT  = 5'b11011;
  localparam logic [4:0] OP_BLT  = 5'b11100;
  localparam logic [4:0] OP_BZ   = 5'b11101;
  localparam logic [4:0] OP_CALL = 5'b11110;
  localparam logic [4:0] OP_RET  = 5'b11111;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_CALL_WR,
    ST_RET_RD,
    ST_RET_WAIT,
    ST_HALT
  } state_e;

endpackage

// File: rtl/cfu_sequencer_if.sv
// Instruction handshake, status and stack RAM bus of the sequencer.
interface cfu_sequencer_if;
  import cfu_pkg::*;

  logic                   INSTR_VALID;
  logic                   READY;
  logic [4:0]             SEL;
  logic [DATA_W-1:0]      R1_READ;
  logic [DATA_W-1:0]      R2_READ;
  logic [DATA_W-1:0]      ADDR;
  logic [PC_W-1:0]        PC;
  logic [SP_W-1:0]        SP;
  logic                   STACK_WE;
  logic                   STACK_RE;
  logic [SP_W-1:0]        STACK_ADDR;
  logic [DATA_W-1:0]      STACK_WDATA;
  logic [DATA_W-1:0]      STACK_RDATA;
  logic                   FAULT;

  modport slave (
    input  INSTR_VALID, SEL, R1_READ, R2_READ, ADDR, STACK_RDATA,
    output READY, PC, SP, STACK_WE, STACK_RE, STACK_ADDR, STACK_WDATA, FAULT
  );

  modport master (
    output INSTR_VALID, SEL, R1_READ, R2_READ, ADDR, STACK_RDATA,
    input  READY, PC, SP, STACK_WE, STACK_RE, STACK_ADDR, STACK_WDATA, FAULT
  );

endinterface

// File: rtl/cfu_branch_eval.sv
// Combinational taken/not-taken decision for jumps and compare branches.
module cfu_branch_eval
  import cfu_pkg::*;
(
  input  logic [4:0]        sel_i,
  input  logic [DATA_W-1:0] r1_i,
  input  logic [DATA_W-1:0] r2_i,
  output logic              taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (sel_i)
      OP_JMP: taken_o = 1'b1;
      OP_BEQ: taken_o = (r1_i == r2_i);
      OP_BNE: taken_o = (r1_i != r2_i);
      OP_BGT: taken_o = (r1_i >  r2_i);
      OP_BLT: taken_o = (r1_i <  r2_i);
      OP_BZ:  taken_o = (r1_i == '0);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cfu_sequencer.sv
// PC / call-stack sequencer: one-cycle branches, multi-cycle CALL/RET against
// an external stack RAM, sticky HALT on stack overflow or underflow.
module cfu_sequencer
  import cfu_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  cfu_sequencer_if.slave bus
);

  localparam logic [SP_W:0]   DEPTH_FULL = STACK_DEPTH[SP_W:0];
  localparam logic [SP_W:0]   DEPTH_ONE  = (SP_W+1)'(1);
  localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   tgt_q;
  logic [SP_W-1:0]   sp_q;
  logic [SP_W:0]     depth_q;

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   tgt;
  logic              taken;
  logic              unused_bits;

  assign pc_inc      = pc_q + PC_ONE;
  assign tgt         = bus.ADDR[PC_W-1:0];
  assign unused_bits = ^{bus.ADDR[DATA_W-1:PC_W], bus.STACK_RDATA[DATA_W-1:PC_W]};

  cfu_branch_eval u_branch_eval (
    .sel_i   (bus.SEL),
    .r1_i    (bus.R1_READ),
    .r2_i    (bus.R2_READ),
    .taken_o (taken)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      tgt_q   <= '0;
      sp_q    <= '1;
      depth_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.INSTR_VALID) begin
            case (bus.SEL)
              OP_CALL: begin
                if (depth_q == DEPTH_FULL) begin
                  state_q <= ST_HALT;
                end else begin
                  tgt_q   <= tgt;
                  state_q <= ST_CALL_WR;
                end
              end
              OP_RET: begin
                if (depth_q == '0) state_q <= ST_HALT;
                else               state_q <= ST_RET_RD;
              end
              default: pc_q <= taken ? tgt : pc_inc;
            endcase
          end
        end
        ST_CALL_WR: begin
          sp_q    <= sp_q - SP_ONE;
          depth_q <= depth_q + DEPTH_ONE;
          pc_q    <= tgt_q;
          state_q <= ST_RUN;
        end
        ST_RET_RD: begin
          state_q <= ST_RET_WAIT;
        end
        ST_RET_WAIT: begin
          pc_q    <= bus.STACK_RDATA[PC_W-1:0];
          sp_q    <= sp_q + SP_ONE;
          depth_q <= depth_q - DEPTH_ONE;
          state_q <= ST_RUN;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Outputs decode from state and registers only; READY depends on state alone.
  assign bus.READY       = (state_q == ST_RUN);
  assign bus.FAULT       = (state_q == ST_HALT);
  assign bus.PC          = pc_q;
  assign bus.SP          = sp_q;
  assign bus.STACK_WE    = (state_q == ST_CALL_WR);
  assign bus.STACK_RE    = (state_q == ST_RET_RD);
  assign bus.STACK_ADDR  = (state_q == ST_RET_RD) ? sp_q + SP_ONE : sp_q;
  assign bus.STACK_WDATA = (state_q == ST_CALL_WR) ? DATA_W'(pc_inc) : '0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (sp_q == SP_W'(STACK_DEPTH - 1) - depth_q[SP_W-1:0]);
      assert (depth_q <= DEPTH_FULL);
    end
  end

endmodule

// File: tb/tb_cfu_sequencer.sv
// Randomised self-checking bench for cfu_sequencer with a call-stack reference model.
module tb_cfu_sequencer;
  import cfu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfu_sequencer_if bus ();

  cfu_sequencer dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // External stack RAM with one-cycle registered read.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.STACK_WE) mem[bus.STACK_ADDR] <= bus.STACK_WDATA;
    if (bus.STACK_RE) bus.STACK_RDATA <= mem[bus.STACK_ADDR];
  end

  int chk  = 0;
  int errs = 0;

  int m_pc;
  int m_depth;
  int m_stack[$];

  function automatic int m_sp();
    return (15 - m_depth) & 15;
  endfunction

  function automatic bit m_taken(logic [4:0] s, int r1, int r2);
    case (s)
      5'b11000: return 1'b1;
      5'b11001: return r1 == r2;
      5'b11010: return r1 != r2;
      5'b11011: return r1 > r2;
      5'b11100: return r1 < r2;
      5'b11101: return r1 == 0;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.INSTR_VALID = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0;
    m_depth = 0;
    m_stack.delete();
  endtask

  // Issue one instruction at a negedge, advance the model, check the outcome.
  // Returns at a negedge with the sequencer ready for the next instruction.
  task automatic exec(input logic [4:0] sel, input logic [7:0] r1, input logic [7:0] r2,
                      input logic [7:0] addr);
    int n;
    int tgt;
    tgt = addr & 31;
    bus.INSTR_VALID = 1'b1;
    bus.SEL = sel; bus.R1_READ = r1; bus.R2_READ = r2; bus.ADDR = addr;
    n = 0;
    while (bus.READY !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bus.READY !== 1'b1) begin
      chk++; errs++;
      $display("FAIL ready_timeout: ready=%b required 1", bus.READY);
      bus.INSTR_VALID = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.INSTR_VALID = 1'b0;
    bus.R1_READ = 8'($urandom); bus.R2_READ = 8'($urandom); bus.ADDR = 8'($urandom);
    @(negedge clk);
    if (sel == OP_CALL && m_depth == 16) begin
      chk++; if (bus.FAULT !== 1'b1) begin errs++; $display("FAIL ovf_fault: got %b required 1", bus.FAULT); end
      chk++; if (bus.READY !== 1'b0) begin errs++; $display("FAIL ovf_ready: got %b required 0", bus.READY); end
      chk++; if (bus.STACK_WE !== 1'b0) begin errs++; $display("FAIL ovf_we: got %b required 0", bus.STACK_WE); end
      chk++; if (bus.PC !== 5'(m_pc)) begin errs++; $display("FAIL ovf_pc: got %0d required %0d", bus.PC, m_pc); end
    end else if (sel == OP_RET && m_depth == 0) begin
      chk++; if (bus.FAULT !== 1'b1) begin errs++; $display("FAIL unf_fault: got %b required 1", bus.FAULT); end
      chk++; if (bus.READY !== 1'b0) begin errs++; $display("FAIL unf_ready: got %b required 0", bus.READY); end
      chk++; if (bus.STACK_RE !== 1'b0) begin errs++; $display("FAIL unf_re: got %b required 0", bus.STACK_RE); end
    end else if (sel == OP_CALL) begin
      chk++;
      if (bus.STACK_WE !== 1'b1 || bus.STACK_ADDR !== 4'(m_sp()) ||
          bus.STACK_WDATA !== 8'((m_pc + 1) & 31) || bus.READY !== 1'b0) begin
        errs++;
        $display("FAIL call_wr: we=%b addr=%0d wdata=%0h ready=%b required we=1 addr=%0d wdata=%0h ready=0",
                 bus.STACK_WE, bus.STACK_ADDR, bus.STACK_WDATA, bus.READY, m_sp(), (m_pc + 1) & 31);
      end
      m_stack.push_back((m_pc + 1) & 31);
      m_pc = tgt;
      m_depth++;
      @(negedge clk);
      chk++;
      if (bus.PC !== 5'(m_pc) || bus.SP !== 4'(m_sp()) || bus.STACK_WE !== 1'b0 || bus.READY !== 1'b1) begin
        errs++;
        $display("FAIL call_done: pc=%0d sp=%0d we=%b ready=%b required pc=%0d sp=%0d we=0 ready=1",
                 bus.PC, bus.SP, bus.STACK_WE, bus.READY, m_pc, m_sp());
      end
    end else if (sel == OP_RET) begin
      chk++;
      if (bus.STACK_RE !== 1'b1 || bus.STACK_ADDR !== 4'((m_sp() + 1) & 15) || bus.READY !== 1'b0) begin
        errs++;
        $display("FAIL ret_rd: re=%b addr=%0d ready=%b required re=1 addr=%0d ready=0",
                 bus.STACK_RE, bus.STACK_ADDR, bus.READY, (m_sp() + 1) & 15);
      end
      @(negedge clk);
      chk++;
      if (bus.STACK_RE !== 1'b0 || bus.READY !== 1'b0 || bus.PC !== 5'(m_pc)) begin
        errs++;
        $display("FAIL ret_wait: re=%b ready=%b pc=%0d required re=0 ready=0 pc=%0d",
                 bus.STACK_RE, bus.READY, bus.PC, m_pc);
      end
      m_pc = m_stack.pop_back();
      m_depth--;
      @(negedge clk);
      chk++;
      if (bus.PC !== 5'(m_pc) || bus.SP !== 4'(m_sp()) || bus.READY !== 1'b1) begin
        errs++;
        $display("FAIL ret_done: pc=%0d sp=%0d ready=%b required pc=%0d sp=%0d ready=1",
                 bus.PC, bus.SP, bus.READY, m_pc, m_sp());
      end
    end else begin
      m_pc = m_taken(sel, r1, r2) ? tgt : ((m_pc + 1) & 31);
      chk++;
      if (bus.PC !== 5'(m_pc) || bus.SP !== 4'(m_sp()) || bus.READY !== 1'b1 || bus.FAULT !== 1'b0) begin
        errs++;
        $display("FAIL step sel=%b: pc=%0d sp=%0d ready=%b fault=%b required pc=%0d sp=%0d ready=1 fault=0",
                 sel, bus.PC, bus.SP, bus.READY, bus.FAULT, m_pc, m_sp());
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk++;
    if (bus.PC !== 5'd0 || bus.SP !== 4'd15 || bus.READY !== 1'b1 || bus.FAULT !== 1'b0 ||
        bus.STACK_WE !== 1'b0 || bus.STACK_RE !== 1'b0 || bus.STACK_ADDR !== 4'd15 ||
        bus.STACK_WDATA !== 8'd0) begin
      errs++;
      $display("FAIL reset: pc=%0d sp=%0d ready=%b fault=%b we=%b re=%b addr=%0d wdata=%0h required 0,15,1,0,0,0,15,0",
               bus.PC, bus.SP, bus.READY, bus.FAULT, bus.STACK_WE, bus.STACK_RE, bus.STACK_ADDR, bus.STACK_WDATA);
    end
  endtask

  task automatic test_nop();
    for (int i = 0; i < 3; i++) exec(5'b00000, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_branches();
    exec(OP_BEQ, 8'h12, 8'h12, 8'h0A);
    exec(OP_BGT, 8'h05, 8'h80, 8'h1C);
    exec(OP_BZ,  8'h00, 8'h33, 8'h1F);
    exec(5'b00000, 8'h00, 8'h00, 8'h00);
    exec(OP_BLT, 8'h05, 8'h80, 8'hE7);
    exec(OP_BNE, 8'h44, 8'h44, 8'h03);
  endtask

  task automatic test_call_ret();
    do_reset();
    exec(OP_JMP, 8'h00, 8'h00, 8'h04);
    exec(OP_CALL, 8'h00, 8'h00, 8'h14);
    exec(OP_RET, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) exec(OP_CALL, 8'h00, 8'h00, 8'($urandom));
    exec(OP_CALL, 8'h00, 8'h00, 8'h09);
    bus.INSTR_VALID = 1'b1; bus.SEL = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk++;
      if (bus.FAULT !== 1'b1 || bus.READY !== 1'b0 || bus.PC !== 5'(m_pc) || bus.SP !== 4'd15 ||
          bus.STACK_WE !== 1'b0) begin
        errs++;
        $display("FAIL halt_hold: fault=%b ready=%b pc=%0d sp=%0d we=%b required 1,0,%0d,15,0",
                 bus.FAULT, bus.READY, bus.PC, bus.SP, bus.STACK_WE, m_pc);
      end
    end
    bus.INSTR_VALID = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    exec(OP_RET, 8'h00, 8'h00, 8'h00);
    do_reset();
    chk++;
    if (bus.FAULT !== 1'b0 || bus.READY !== 1'b1) begin
      errs++; $display("FAIL unf_clear: fault=%b ready=%b required 0,1", bus.FAULT, bus.READY);
    end
  endtask

  task automatic test_reset_mid_call();
    do_reset();
    exec(OP_JMP, 8'h00, 8'h00, 8'h07);
    bus.INSTR_VALID = 1'b1; bus.SEL = OP_CALL; bus.ADDR = 8'h15;
    @(posedge clk);
    #1 bus.INSTR_VALID = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    m_pc = 0; m_depth = 0; m_stack.delete();
    chk++;
    if (bus.PC !== 5'd0 || bus.SP !== 4'd15 || bus.STACK_WE !== 1'b0 || bus.READY !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid_call: pc=%0d sp=%0d we=%b ready=%b required 0,15,0,1",
               bus.PC, bus.SP, bus.STACK_WE, bus.READY);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exec(OP_CALL, 8'h00, 8'h00, 8'h09);
    bus.INSTR_VALID = 1'b1; bus.SEL = OP_RET;
    @(posedge clk);
    #1 bus.SEL = OP_BNE; bus.R1_READ = 8'h07; bus.R2_READ = 8'h07; bus.ADDR = 8'h11;
    @(negedge clk);
    chk++;
    if (bus.READY !== 1'b0 || bus.STACK_RE !== 1'b1 || bus.PC !== 5'd9) begin
      errs++; $display("FAIL b2b_rd: ready=%b re=%b pc=%0d required 0,1,9", bus.READY, bus.STACK_RE, bus.PC);
    end
    @(posedge clk);
    #1 bus.R1_READ = 8'h03; bus.R2_READ = 8'h04;
    @(negedge clk);
    chk++;
    if (bus.READY !== 1'b0 || bus.PC !== 5'd9) begin
      errs++; $display("FAIL b2b_wait: ready=%b pc=%0d required 0,9", bus.READY, bus.PC);
    end
    @(negedge clk);
    m_pc = m_stack.pop_back(); m_depth--;
    chk++;
    if (bus.READY !== 1'b1 || bus.PC !== 5'(m_pc) || bus.SP !== 4'd15) begin
      errs++; $display("FAIL b2b_ret: ready=%b pc=%0d sp=%0d required 1,%0d,15", bus.READY, bus.PC, bus.SP, m_pc);
    end
    @(posedge clk);
    #1 bus.INSTR_VALID = 1'b0;
    m_pc = 17;
    @(negedge clk);
    chk++;
    if (bus.PC !== 5'(m_pc)) begin
      errs++; $display("FAIL b2b_bne: pc=%0d required %0d", bus.PC, m_pc);
    end
  endtask

  task automatic test_random();
    logic [4:0] sel;
    logic [7:0] r1, r2;
    int kind;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      r1 = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 8'($urandom);
      if (kind < 2 && m_depth < 16) sel = OP_CALL;
      else if (kind < 4 && m_depth > 0) sel = OP_RET;
      else begin
        sel = 5'($urandom_range(0, 29));
        if (sel > 5'd5) sel = 5'b11000 + 5'(sel % 6);
      end
      exec(sel, r1, r2, 8'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    bus.INSTR_VALID = 1'b0; bus.SEL = '0; bus.R1_READ = '0; bus.R2_READ = '0; bus.ADDR = '0;
    bus.STACK_RDATA = '0;
    test_reset();
    test_nop();
    test_branches();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_reset_mid_call();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
